// File: rtl/floo_axi_pkg.sv
// Minimal AXI handshake view used by the performance monitor.
// Only the valid/ready/last bits the monitor observes are carried.
package floo_axi_pkg;

  typedef struct packed {
    logic aw_valid;
    logic w_valid;
    logic b_ready;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic b_valid;
    logic ar_ready;
    logic r_valid;
    logic r_last;
  } axi_rsp_t;

endpackage

// File: rtl/floo_sat_updown_cnt.sv
// Saturating up/down counter with synchronous clear.
// ovf_o/udf_o flag an attempted step past max/min in the current cycle.
module floo_sat_updown_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] q_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam logic [Width-1:0] MaxVal = '1;

  logic [Width-1:0] q_d, q_q;

  // Next count: clear wins; simultaneous inc and dec cancel out.
  always_comb begin
    q_d   = q_q;
    ovf_o = inc_i & ~dec_i & (q_q == MaxVal);
    udf_o = dec_i & ~inc_i & (q_q == '0);
    if (clear_i) begin
      q_d = '0;
    end else if (inc_i && !dec_i && !ovf_o) begin
      q_d = q_q + Width'(1);
    end else if (dec_i && !inc_i && !udf_o) begin
      q_d = q_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/floo_axi_perf_monitor.sv
// Non-intrusive per-port AXI monitor: live in-flight AR/AW counts and
// R/W beat counts snapshotted at the end of each fixed measurement window.
module floo_axi_perf_monitor #(
  parameter int unsigned NumPorts     = 2,
  parameter int unsigned CntWidth     = 16,
  parameter int unsigned WindowCycles = 1024,
  parameter type         axi_req_t    = floo_axi_pkg::axi_req_t,
  parameter type         axi_rsp_t    = floo_axi_pkg::axi_rsp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic                               clear_i,
  input  axi_req_t [NumPorts-1:0]            req_i,
  input  axi_rsp_t [NumPorts-1:0]            rsp_i,
  output logic     [NumPorts-1:0][CntWidth-1:0] ar_in_flight_o,
  output logic     [NumPorts-1:0][CntWidth-1:0] aw_in_flight_o,
  output logic     [NumPorts-1:0][CntWidth-1:0] r_beats_o,
  output logic     [NumPorts-1:0][CntWidth-1:0] w_beats_o,
  output logic                               window_valid_o,
  output logic     [NumPorts-1:0]            err_o
);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam int unsigned TimerW = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
  typedef logic [TimerW-1:0] timer_t;
  localparam timer_t TimerLast = timer_t'(WindowCycles - 1);

  timer_t timer_d, timer_q;
  logic   wrap;
  logic   window_valid_d, window_valid_q;

  // Shared window timer; wrap marks the last enabled cycle of a window.
  always_comb begin
    wrap           = en_i & (timer_q == TimerLast);
    timer_d        = timer_q;
    window_valid_d = 1'b0;
    if (clear_i) begin
      timer_d = '0;
    end else if (wrap) begin
      timer_d        = '0;
      window_valid_d = 1'b1;
    end else if (en_i) begin
      timer_d = timer_q + timer_t'(1);
    end
  end

  // Timer and snapshot-valid pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q        <= '0;
      window_valid_q <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      window_valid_q <= window_valid_d;
    end
  end

  assign window_valid_o = window_valid_q;

  for (genvar p = 0; p < NumPorts; p++) begin : gen_port
    logic ar_hs, r_last_hs, aw_hs, b_hs, r_inc, w_inc;
    logic ar_ovf, ar_udf, aw_ovf, aw_udf, r_ovf, w_ovf;
    logic r_udf_unused, w_udf_unused;
    cnt_t r_acc, w_acc;
    cnt_t r_snap_d, r_snap_q, w_snap_d, w_snap_q;
    logic err_d, err_q;

    assign ar_hs     = req_i[p].ar_valid & rsp_i[p].ar_ready;
    assign r_last_hs = rsp_i[p].r_valid & req_i[p].r_ready & rsp_i[p].r_last;
    assign aw_hs     = req_i[p].aw_valid & rsp_i[p].aw_ready;
    assign b_hs      = rsp_i[p].b_valid & req_i[p].b_ready;
    // Beats only accumulate while the window is running.
    assign r_inc     = en_i & rsp_i[p].r_valid & req_i[p].r_ready;
    assign w_inc     = en_i & req_i[p].w_valid & rsp_i[p].w_ready;

    floo_sat_updown_cnt #(.Width(CntWidth)) i_ar_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .inc_i   (ar_hs),
      .dec_i   (r_last_hs),
      .q_o     (ar_in_flight_o[p]),
      .ovf_o   (ar_ovf),
      .udf_o   (ar_udf)
    );

    floo_sat_updown_cnt #(.Width(CntWidth)) i_aw_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .inc_i   (aw_hs),
      .dec_i   (b_hs),
      .q_o     (aw_in_flight_o[p]),
      .ovf_o   (aw_ovf),
      .udf_o   (aw_udf)
    );

    // Accumulators restart at wrap; the wrap-cycle beat goes into the snapshot.
    floo_sat_updown_cnt #(.Width(CntWidth)) i_r_acc (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i | wrap),
      .inc_i   (r_inc),
      .dec_i   (1'b0),
      .q_o     (r_acc),
      .ovf_o   (r_ovf),
      .udf_o   (r_udf_unused)
    );

    floo_sat_updown_cnt #(.Width(CntWidth)) i_w_acc (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i | wrap),
      .inc_i   (w_inc),
      .dec_i   (1'b0),
      .q_o     (w_acc),
      .ovf_o   (w_ovf),
      .udf_o   (w_udf_unused)
    );

    // Snapshot capture and sticky error accumulation.
    always_comb begin
      r_snap_d = r_snap_q;
      w_snap_d = w_snap_q;
      err_d    = err_q | ar_ovf | ar_udf | aw_ovf | aw_udf | r_ovf | w_ovf;
      if (clear_i) begin
        r_snap_d = '0;
        w_snap_d = '0;
        err_d    = 1'b0;
      end else if (wrap) begin
        r_snap_d = r_acc + cnt_t'(r_inc & ~r_ovf);
        w_snap_d = w_acc + cnt_t'(w_inc & ~w_ovf);
      end
    end

    // Snapshot and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_snap_q <= '0;
        w_snap_q <= '0;
        err_q    <= 1'b0;
      end else begin
        r_snap_q <= r_snap_d;
        w_snap_q <= w_snap_d;
        err_q    <= err_d;
      end
    end

    assign r_beats_o[p] = r_snap_q;
    assign w_beats_o[p] = w_snap_q;
    assign err_o[p]     = err_q;
  end

endmodule

// File: tb/tb_floo_axi_perf_monitor.sv
// Randomized bench for floo_axi_perf_monitor against an integer reference model.
module tb_floo_axi_perf_monitor;

  localparam int NP   = 2;
  localparam int CW   = 4;
  localparam int WC   = 24;
  localparam int MAXV = (1 << CW) - 1;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic en_i    = 1'b0;
  logic clear_i = 1'b0;
  floo_axi_pkg::axi_req_t [NP-1:0] req;
  floo_axi_pkg::axi_rsp_t [NP-1:0] rsp;
  logic [NP-1:0][CW-1:0] ar_if, aw_if, r_beats, w_beats;
  logic                  window_valid;
  logic [NP-1:0]         err;

  floo_axi_perf_monitor #(
    .NumPorts     (NP),
    .CntWidth     (CW),
    .WindowCycles (WC),
    .axi_req_t    (floo_axi_pkg::axi_req_t),
    .axi_rsp_t    (floo_axi_pkg::axi_rsp_t)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .clear_i        (clear_i),
    .req_i          (req),
    .rsp_i          (rsp),
    .ar_in_flight_o (ar_if),
    .aw_in_flight_o (aw_if),
    .r_beats_o      (r_beats),
    .w_beats_o      (w_beats),
    .window_valid_o (window_valid),
    .err_o          (err)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state, plain integers.
  int m_ar[NP], m_aw[NP], m_racc[NP], m_wacc[NP], m_rs[NP], m_ws[NP];
  bit m_err[NP];
  int m_timer;
  bit m_wv;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_ar[p] = 0; m_aw[p] = 0; m_racc[p] = 0; m_wacc[p] = 0;
      m_rs[p] = 0; m_ws[p] = 0; m_err[p] = 0;
    end
    m_timer = 0;
    m_wv    = 0;
  endtask

  // Moves an in-flight count by +1/-1/0, clamping to [0, MAXV] with error.
  task automatic step_if(inout int cnt, inout bit e, input int delta);
    if (delta > 0) begin
      if (cnt == MAXV) e = 1; else cnt++;
    end else if (delta < 0) begin
      if (cnt == 0) e = 1; else cnt--;
    end
  endtask

  task automatic model_step();
    bit wrap;
    int nr, nw;
    if (clear_i) begin
      model_reset();
      return;
    end
    wrap = en_i && (m_timer == WC - 1);
    for (int p = 0; p < NP; p++) begin
      step_if(m_ar[p], m_err[p], int'(req[p].ar_valid & rsp[p].ar_ready)
              - int'(rsp[p].r_valid & req[p].r_ready & rsp[p].r_last));
      step_if(m_aw[p], m_err[p], int'(req[p].aw_valid & rsp[p].aw_ready)
              - int'(rsp[p].b_valid & req[p].b_ready));
      nr = m_racc[p] + int'(en_i & rsp[p].r_valid & req[p].r_ready);
      nw = m_wacc[p] + int'(en_i & req[p].w_valid & rsp[p].w_ready);
      if (nr > MAXV) begin nr = MAXV; m_err[p] = 1; end
      if (nw > MAXV) begin nw = MAXV; m_err[p] = 1; end
      if (wrap) begin
        m_rs[p] = nr; m_ws[p] = nw; m_racc[p] = 0; m_wacc[p] = 0;
      end else begin
        m_racc[p] = nr; m_wacc[p] = nw;
      end
    end
    m_wv = wrap;
    if (en_i) m_timer = wrap ? 0 : m_timer + 1;
  endtask

  task automatic check_all();
    check_eq("window_valid", 32'(window_valid), 32'(m_wv));
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("ar_in_flight[%0d]", p), 32'(ar_if[p]), 32'(m_ar[p]));
      check_eq($sformatf("aw_in_flight[%0d]", p), 32'(aw_if[p]), 32'(m_aw[p]));
      check_eq($sformatf("r_beats[%0d]", p), 32'(r_beats[p]), 32'(m_rs[p]));
      check_eq($sformatf("w_beats[%0d]", p), 32'(w_beats[p]), 32'(m_ws[p]));
      check_eq($sformatf("err[%0d]", p), 32'(err[p]), 32'(m_err[p]));
    end
  endtask

  // Inputs are applied at negedge; model advances with the same inputs.
  task automatic run_cycle();
    model_step();
    @(posedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    req = '0;
    rsp = '0;
  endtask

  // mode 0: mixed traffic, 1: streaming W/R beats, 2: request-heavy
  task automatic randomize_inputs(input int mode);
    for (int p = 0; p < NP; p++) begin
      bit rare_r, rare_b;
      rare_r = (m_ar[p] == 0) || (mode == 2);
      rare_b = (m_aw[p] == 0) || (mode == 2);
      req[p].ar_valid = ($urandom_range(0, 2) == 0);
      rsp[p].ar_ready = $urandom_range(0, 1);
      req[p].aw_valid = ($urandom_range(0, 2) == 0);
      rsp[p].aw_ready = $urandom_range(0, 1);
      req[p].w_valid  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rsp[p].w_ready  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rsp[p].r_valid  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      req[p].r_ready  = $urandom_range(0, 1);
      rsp[p].r_last   = rare_r ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) == 0);
      rsp[p].b_valid  = rare_b ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
      req[p].b_ready  = $urandom_range(0, 1);
    end
    en_i    = (mode == 1) ? 1'b1 : ($urandom_range(0, 15) != 0);
    clear_i = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle windows with the timer running.
    en_i = 1'b1;
    for (int i = 0; i < 2 * WC + 3; i++) run_cycle();

    for (int i = 0; i < 2400; i++) begin
      if (i == 1234) begin
        // Asynchronous reset in the middle of a window.
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
      end
      randomize_inputs((i / 150) % 3);
      run_cycle();
    end

    // Clear together with AR and W handshakes: nothing gets counted.
    idle_inputs();
    en_i = 1'b1;
    req[0].ar_valid = 1'b1;
    rsp[0].ar_ready = 1'b1;
    req[0].w_valid  = 1'b1;
    rsp[0].w_ready  = 1'b1;
    run_cycle();
    clear_i = 1'b1;
    run_cycle();
    clear_i = 1'b0;
    idle_inputs();
    run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
